// File: rtl/csr_file_pkg.sv
// Shared constants for the machine-mode CSR file: address map, mstatus bit
// positions, write masks and small decode helpers.
package csr_file_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned CNT_W   = 64;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_AW-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MCOUNTINH = 12'h320;
    localparam logic [CSR_AW-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_AW-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [CSR_AW-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_AW-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_AW-1:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [CSR_AW-1:0] CSR_CYCLE     = 12'hC00;
    localparam logic [CSR_AW-1:0] CSR_INSTRET   = 12'hC02;
    localparam logic [CSR_AW-1:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [CSR_AW-1:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [CSR_AW-1:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MCOUNTINH_CY = 0;
    localparam int unsigned MCOUNTINH_IR = 2;
    localparam int unsigned MIP_MSIP     = 3;
    localparam int unsigned MIP_MTIP     = 7;
    localparam int unsigned MIP_MEIP     = 11;

    localparam logic [XLEN-1:0] MSTATUS_WMASK   = 32'h0000_0088;
    localparam logic [XLEN-1:0] MIE_WMASK       = 32'h0000_0888;
    localparam logic [XLEN-1:0] MTVEC_WMASK     = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] MEPC_WMASK      = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] MCOUNTINH_WMASK = 32'h0000_0005;

    localparam logic            WRITE_ENABLE  = 1'b1;
    localparam logic            WRITE_DISABLE = 1'b0;
    localparam logic [XLEN-1:0] ZERO_WORD     = 32'h0000_0000;

    function automatic logic csr_writable(input logic [CSR_AW-1:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MCOUNTINH,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
                csr_writable = WRITE_ENABLE;
            default:
                csr_writable = WRITE_DISABLE;
        endcase
    endfunction

    // Bits a software write may change; read-only/unimplemented addresses get none.
    function automatic logic [XLEN-1:0] csr_wmask(input logic [CSR_AW-1:0] addr);
        case (addr)
            CSR_MSTATUS:   csr_wmask = MSTATUS_WMASK;
            CSR_MIE:       csr_wmask = MIE_WMASK;
            CSR_MTVEC:     csr_wmask = MTVEC_WMASK;
            CSR_MEPC:      csr_wmask = MEPC_WMASK;
            CSR_MCOUNTINH: csr_wmask = MCOUNTINH_WMASK;
            default:       csr_wmask = csr_writable(addr) ? ~ZERO_WORD : ZERO_WORD;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit performance counter with per-half software write; a write to either
// half suppresses that cycle's increment.
module csr_counter64
    import csr_file_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inhibit_i,
    input  logic             incr_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [XLEN-1:0]  wd_i,
    output logic [CNT_W-1:0] value_o
);

    logic [CNT_W-1:0] r_value;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_value <= '0;
        end else if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) r_value[XLEN-1:0]     <= wd_i;
            if (wr_hi_i) r_value[CNT_W-1:XLEN] <= wd_i;
        end else if (incr_i && !inhibit_i) begin
            r_value <= r_value + 64'd1;
        end
    end

    assign value_o = r_value;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: writeback-port writes, trap/mret updates, 64-bit
// mcycle/minstret, and a combinational read port with same-cycle write bypass.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_wa_i,
    input  logic [31:0] csr_wd_i,
    input  logic        instret_incr_i,
    input  logic [31:0] csr_ra_i,
    output logic [31:0] csr_rd_o,
    output logic        csr_illegal_o,
    input  logic        trap_we_i,
    input  logic [31:0] trap_mepc_i,
    input  logic [31:0] trap_mcause_i,
    input  logic [31:0] trap_mtval_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        irq_sw_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mstatus_mie_o,
    output logic [31:0] mie_o
);

    logic [XLEN-1:0] r_mstatus, r_mie, r_mtvec, r_mcountinh, r_mscratch;
    logic [XLEN-1:0] r_mepc, r_mcause, r_mtval;

    logic [CSR_AW-1:0] w_waddr, w_raddr;
    logic [XLEN-1:0]   w_wmasked, w_mip, w_rd;
    logic [CNT_W-1:0]  w_mcycle, w_minstret;
    logic              w_illegal, w_unused;

    assign w_waddr   = csr_wa_i[CSR_AW-1:0];
    assign w_raddr   = csr_ra_i[CSR_AW-1:0];
    assign w_wmasked = csr_wd_i & csr_wmask(w_waddr);
    assign w_unused  = ^{csr_wa_i[XLEN-1:CSR_AW], csr_ra_i[XLEN-1:CSR_AW]};

    always_comb begin
        w_mip               = ZERO_WORD;
        w_mip[MIP_MSIP]     = irq_sw_i;
        w_mip[MIP_MTIP]     = irq_timer_i;
        w_mip[MIP_MEIP]     = irq_ext_i;
    end

    csr_counter64 u_mcycle (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inhibit_i (r_mcountinh[MCOUNTINH_CY]),
        .incr_i    (1'b1),
        .wr_lo_i   (csr_we_i && (w_waddr == CSR_MCYCLE)),
        .wr_hi_i   (csr_we_i && (w_waddr == CSR_MCYCLEH)),
        .wd_i      (csr_wd_i),
        .value_o   (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inhibit_i (r_mcountinh[MCOUNTINH_IR]),
        .incr_i    (instret_incr_i),
        .wr_lo_i   (csr_we_i && (w_waddr == CSR_MINSTRET)),
        .wr_hi_i   (csr_we_i && (w_waddr == CSR_MINSTRETH)),
        .wd_i      (csr_wd_i),
        .value_o   (w_minstret)
    );

    // Trap and mret own mstatus/mepc/mcause/mtval in their cycle; other CSR writes still land.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mstatus   <= ZERO_WORD;
            r_mie       <= ZERO_WORD;
            r_mtvec     <= MTVEC_RST;
            r_mcountinh <= ZERO_WORD;
            r_mscratch  <= ZERO_WORD;
            r_mepc      <= ZERO_WORD;
            r_mcause    <= ZERO_WORD;
            r_mtval     <= ZERO_WORD;
        end else begin
            if (csr_we_i) begin
                case (w_waddr)
                    CSR_MIE:       r_mie       <= w_wmasked;
                    CSR_MTVEC:     r_mtvec     <= w_wmasked;
                    CSR_MCOUNTINH: r_mcountinh <= w_wmasked;
                    CSR_MSCRATCH:  r_mscratch  <= w_wmasked;
                    default: ;
                endcase
            end
            if (trap_we_i) begin
                r_mepc                  <= trap_mepc_i & MEPC_WMASK;
                r_mcause                <= trap_mcause_i;
                r_mtval                 <= trap_mtval_i;
                r_mstatus[MSTATUS_MPIE] <= r_mstatus[MSTATUS_MIE];
                r_mstatus[MSTATUS_MIE]  <= 1'b0;
            end else if (mret_i) begin
                r_mstatus[MSTATUS_MIE]  <= r_mstatus[MSTATUS_MPIE];
                r_mstatus[MSTATUS_MPIE] <= 1'b1;
            end else if (csr_we_i) begin
                case (w_waddr)
                    CSR_MSTATUS: r_mstatus <= w_wmasked;
                    CSR_MEPC:    r_mepc    <= w_wmasked;
                    CSR_MCAUSE:  r_mcause  <= w_wmasked;
                    CSR_MTVAL:   r_mtval   <= w_wmasked;
                    default: ;
                endcase
            end
        end
    end

    // Read mux; a write to the same writable address in this cycle is forwarded.
    always_comb begin
        w_rd      = ZERO_WORD;
        w_illegal = 1'b0;
        case (w_raddr)
            CSR_MSTATUS:               w_rd = r_mstatus;
            CSR_MISA:                  w_rd = MISA_VAL;
            CSR_MIE:                   w_rd = r_mie;
            CSR_MTVEC:                 w_rd = r_mtvec;
            CSR_MCOUNTINH:             w_rd = r_mcountinh;
            CSR_MSCRATCH:              w_rd = r_mscratch;
            CSR_MEPC:                  w_rd = r_mepc;
            CSR_MCAUSE:                w_rd = r_mcause;
            CSR_MTVAL:                 w_rd = r_mtval;
            CSR_MIP:                   w_rd = w_mip;
            CSR_MCYCLE,   CSR_CYCLE:   w_rd = w_mcycle[XLEN-1:0];
            CSR_MCYCLEH,  CSR_CYCLEH:  w_rd = w_mcycle[CNT_W-1:XLEN];
            CSR_MINSTRET, CSR_INSTRET: w_rd = w_minstret[XLEN-1:0];
            CSR_MINSTRETH,CSR_INSTRETH:w_rd = w_minstret[CNT_W-1:XLEN];
            CSR_MHARTID:               w_rd = HART_ID;
            default:                   w_illegal = 1'b1;
        endcase
        if (csr_we_i && (w_waddr == w_raddr) && csr_writable(w_waddr)) begin
            w_rd = w_wmasked;
        end
    end

    assign csr_rd_o      = w_rd;
    assign csr_illegal_o = w_illegal;
    assign mtvec_o       = r_mtvec;
    assign mepc_o        = r_mepc;
    assign mstatus_mie_o = r_mstatus[MSTATUS_MIE];
    assign mie_o         = r_mie;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: hand-computed expectations for reset, bypass,
// counter carry/wrap/inhibit, trap/mret priority, masking and illegal reads.
module tb_csr_file;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        csr_we_i = 1'b0;
    logic [31:0] csr_wa_i = '0;
    logic [31:0] csr_wd_i = '0;
    logic        instret_incr_i = 1'b0;
    logic [31:0] csr_ra_i = '0;
    logic [31:0] csr_rd_o;
    logic        csr_illegal_o;
    logic        trap_we_i = 1'b0;
    logic [31:0] trap_mepc_i = '0;
    logic [31:0] trap_mcause_i = '0;
    logic [31:0] trap_mtval_i = '0;
    logic        mret_i = 1'b0;
    logic        irq_ext_i = 1'b0;
    logic        irq_timer_i = 1'b0;
    logic        irq_sw_i = 1'b0;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mstatus_mie_o;
    logic [31:0] mie_o;

    int n_chk = 0;
    int n_bad = 0;

    csr_file dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .csr_we_i       (csr_we_i),
        .csr_wa_i       (csr_wa_i),
        .csr_wd_i       (csr_wd_i),
        .instret_incr_i (instret_incr_i),
        .csr_ra_i       (csr_ra_i),
        .csr_rd_o       (csr_rd_o),
        .csr_illegal_o  (csr_illegal_o),
        .trap_we_i      (trap_we_i),
        .trap_mepc_i    (trap_mepc_i),
        .trap_mcause_i  (trap_mcause_i),
        .trap_mtval_i   (trap_mtval_i),
        .mret_i         (mret_i),
        .irq_ext_i      (irq_ext_i),
        .irq_timer_i    (irq_timer_i),
        .irq_sw_i       (irq_sw_i),
        .mtvec_o        (mtvec_o),
        .mepc_o         (mepc_o),
        .mstatus_mie_o  (mstatus_mie_o),
        .mie_o          (mie_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        csr_ra_i = addr;
        #1;
        check(tag, csr_rd_o, exp);
    endtask

    task automatic csr_wr(input logic [31:0] addr, input logic [31:0] data);
        csr_we_i = 1'b1;
        csr_wa_i = addr;
        csr_wd_i = data;
    endtask

    initial begin
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        rd_chk("rst_mcycle", 32'hB00, 32'h0);
        check("rst_mtvec_o", mtvec_o, 32'h0);
        check("rst_mepc_o", mepc_o, 32'h0);
        check("rst_mie_o", mie_o, 32'h0);
        check("rst_mstatus_mie", {31'h0, mstatus_mie_o}, 32'h0);
        rd_chk("rst_mstatus", 32'h300, 32'h0);
        check("illegal_mstatus", {31'h0, csr_illegal_o}, 32'h0);

        repeat (10) tick();
        rd_chk("idle_mcycle10", 32'hB00, 32'd10);
        rd_chk("idle_minstret0", 32'hB02, 32'h0);
        rd_chk("idle_mtvec", 32'h305, 32'h0);

        // mscratch write with same-cycle read bypass, then stored value
        csr_wr(32'h340, 32'hDEAD_BEEF);
        rd_chk("bypass_mscratch", 32'h340, 32'hDEAD_BEEF);
        tick();
        csr_we_i = 1'b0;
        rd_chk("stored_mscratch", 32'h340, 32'hDEAD_BEEF);
        rd_chk("upper_addr_ignored", 32'hFFFF_F340, 32'hDEAD_BEEF);

        // low->high carry
        csr_wr(32'hB00, 32'hFFFF_FFFF);
        tick();
        csr_wr(32'hB80, 32'h0);
        tick();
        csr_we_i = 1'b0;
        tick();
        rd_chk("carry_mcycleh", 32'hB80, 32'h1);
        rd_chk("carry_mcycle", 32'hB00, 32'h0);
        rd_chk("carry_cycleh_alias", 32'hC80, 32'h1);

        // 64-bit wrap to zero
        csr_wr(32'hB00, 32'hFFFF_FFFF);
        tick();
        csr_wr(32'hB80, 32'hFFFF_FFFF);
        tick();
        csr_we_i = 1'b0;
        tick();
        rd_chk("wrap_mcycleh", 32'hB80, 32'h0);
        rd_chk("wrap_mcycle", 32'hB00, 32'h0);

        // minstret: 3 counted pulses, then 2 inhibited
        instret_incr_i = 1'b1;
        repeat (3) tick();
        instret_incr_i = 1'b0;
        csr_wr(32'h320, 32'h0000_00FE);
        tick();
        csr_we_i = 1'b0;
        rd_chk("mcountinh_masked", 32'h320, 32'h4);
        instret_incr_i = 1'b1;
        repeat (2) tick();
        instret_incr_i = 1'b0;
        rd_chk("minstret_3", 32'hB02, 32'd3);
        rd_chk("instret_alias", 32'hC02, 32'd3);
        rd_chk("minstreth_0", 32'hB82, 32'h0);

        // mstatus masking, then trap with colliding mepc write
        csr_wr(32'h300, 32'hFFFF_FFFF);
        tick();
        rd_chk("mstatus_mask", 32'h300, 32'h88);
        csr_wr(32'h300, 32'h0000_0008);
        tick();
        csr_we_i = 1'b0;
        rd_chk("mstatus_mie_only", 32'h300, 32'h08);
        check("mie_out_set", {31'h0, mstatus_mie_o}, 32'h1);
        trap_we_i     = 1'b1;
        trap_mepc_i   = 32'h8000_0103;
        trap_mcause_i = 32'h8000_000B;
        trap_mtval_i  = 32'h0000_1234;
        csr_wr(32'h341, 32'h5555_5554);
        tick();
        trap_we_i = 1'b0;
        csr_we_i  = 1'b0;
        check("trap_mepc_o", mepc_o, 32'h8000_0100);
        rd_chk("trap_mcause", 32'h342, 32'h8000_000B);
        rd_chk("trap_mtval", 32'h343, 32'h0000_1234);
        rd_chk("trap_mstatus", 32'h300, 32'h80);
        check("trap_mie_out", {31'h0, mstatus_mie_o}, 32'h0);

        // mret with a concurrent write to a non-trap CSR that must land
        mret_i = 1'b1;
        csr_wr(32'h340, 32'h0000_1111);
        tick();
        mret_i   = 1'b0;
        csr_we_i = 1'b0;
        rd_chk("mret_mstatus", 32'h300, 32'h88);
        check("mret_mie_out", {31'h0, mstatus_mie_o}, 32'h1);
        rd_chk("mret_mscratch", 32'h340, 32'h0000_1111);

        // masks on mtvec/mie, live mip, hartid
        csr_wr(32'h305, 32'h0000_1003);
        tick();
        csr_wr(32'h304, 32'hFFFF_FFFF);
        tick();
        csr_we_i = 1'b0;
        check("mtvec_o_mask", mtvec_o, 32'h0000_1000);
        check("mie_o_mask", mie_o, 32'h0000_0888);
        irq_sw_i  = 1'b1;
        irq_ext_i = 1'b1;
        rd_chk("mip_sw_ext", 32'h344, 32'h0000_0808);
        irq_sw_i    = 1'b0;
        irq_ext_i   = 1'b0;
        irq_timer_i = 1'b1;
        rd_chk("mip_timer", 32'h344, 32'h0000_0080);
        irq_timer_i = 1'b0;
        rd_chk("mhartid", 32'hF14, 32'h0);

        // unimplemented address and read-only misa
        rd_chk("illegal_rd", 32'h7C0, 32'h0);
        check("illegal_flag", {31'h0, csr_illegal_o}, 32'h1);
        csr_wr(32'h301, 32'h0);
        rd_chk("misa_no_bypass", 32'h301, 32'h4000_0100);
        tick();
        csr_we_i = 1'b0;
        rd_chk("misa_ro", 32'h301, 32'h4000_0100);
        check("misa_legal", {31'h0, csr_illegal_o}, 32'h0);

        // reset wins over a concurrent write
        rst_i = 1'b1;
        csr_wr(32'h340, 32'hAAAA_5555);
        tick();
        rst_i    = 1'b0;
        csr_we_i = 1'b0;
        rd_chk("rst_over_wr", 32'h340, 32'h0);
        check("rst2_mtvec_o", mtvec_o, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR storage at the consumer end of the writeback interface.
- Accepts CSR writes and the retired-instruction pulse from the LSU/writeback pipeline register.
- Serves a combinational CSR read port to decode, with same-cycle write bypass.
- Maintains the 64-bit mcycle/minstret counters and takes trap updates from the exception control unit.

Parameters:
- HART_ID, 32'h0, value returned by mhartid.
- MISA_VAL, 32'h4000_0100, value returned by misa (RV32I).
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- csr_we_i  in  1  writeback-stage CSR write enable.
- csr_wa_i  in  32  CSR write address; bits [11:0] decoded, upper bits ignored.
- csr_wd_i  in  32  CSR write data.
- instret_incr_i  in  1  one instruction retired this cycle.
- csr_ra_i  in  32  read address from decode; bits [11:0] decoded.
- csr_rd_o  out  32  read data, combinational.
- csr_illegal_o  out  1  csr_ra_i is not an implemented address.
- trap_we_i  in  1  exception unit commits a trap this cycle.
- trap_mepc_i  in  32  trap PC.
- trap_mcause_i  in  32  trap cause.
- trap_mtval_i  in  32  trap value.
- mret_i  in  1  mret commits this cycle.
- irq_ext_i, irq_timer_i, irq_sw_i  in  1 each  raw interrupt lines, reflected in mip.
- mtvec_o  out  32  current mtvec.
- mepc_o  out  32  current mepc.
- mstatus_mie_o  out  1  global interrupt enable.
- mie_o  out  32  current mie.

Behaviour:
- Reset (synchronous, rst_i=1 at posedge):
  - mstatus=0, mie=0, mtvec=MTVEC_RST, mscratch=0, mepc=0, mcause=0, mtval=0, mcountinhibit=0, mcycle=0, minstret=0.
  - Outputs follow register values. Reset wins over every other input in the same cycle.
- Address map and access:
  - 0x300 mstatus: only MIE[3] and MPIE[7] writable; other bits read 0.
  - 0x301 misa: RO, returns MISA_VAL.
  - 0x304 mie: only bits 3, 7, 11 writable.
  - 0x305 mtvec: bits [1:0] forced 0.
  - 0x320 mcountinhibit: bit0 CY, bit2 IR writable.
  - 0x340 mscratch.
  - 0x341 mepc: bits [1:0] forced 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0x344 mip: RO, bits 3/7/11 = sw/timer/ext.
  - 0xB00/0xB80 mcycle low/high.
  - 0xB02/0xB82 minstret low/high.
  - 0xC00/0xC80/0xC02/0xC82: RO aliases of the counters.
  - 0xF14 mhartid: RO, returns HART_ID.
  - Writes to RO or unimplemented addresses are silently dropped.
- Read: csr_rd_o is combinational from csr_ra_i.
  - Unimplemented address: csr_rd_o=0 and csr_illegal_o=1.
  - Bypass: if csr_we_i=1 and csr_wa_i[11:0]==csr_ra_i[11:0] for a writable register, csr_rd_o returns the masked csr_wd_i.
- Write latency: the register updates at the posedge following csr_we_i=1.
- Counters:
  - mcycle increments by 1 every cycle unless mcountinhibit.CY=1.
  - minstret increments when instret_incr_i=1 unless mcountinhibit.IR=1.
  - Both are 64-bit; the carry from low into high is handled in the same cycle. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A software write to either half replaces that half and suppresses the increment of the whole counter that cycle; the other half holds.
- Trap (trap_we_i=1), all in one cycle:
  - mepc<=trap_mepc_i & ~3, mcause<=trap_mcause_i, mtval<=trap_mtval_i.
  - MPIE<=MIE, MIE<=0.
- mret (mret_i=1): MIE<=MPIE, MPIE<=1.
- Simultaneous events, priority rst_i > trap_we_i > mret_i > csr_we_i:
  - A csr_we_i targeting mstatus/mepc/mcause/mtval in a trap or mret cycle is dropped.
  - A csr_we_i to any other CSR still applies.
  - trap_we_i and mret_i together are illegal upstream; trap wins.
- mip is not stored; it is recomputed each cycle from the raw interrupt lines.

Decomposition:
- Shared package (defines):
  - CSR address constants (CSR_MSTATUS ... CSR_MHARTID).
  - mstatus bit indices (MSTATUS_MIE=3, MSTATUS_MPIE=7).
  - Write masks for mstatus, mie, mtvec, mepc.
  - The existing WRITE_ENABLE/WRITE_DISABLE and ZERO_WORD constants.
- One sub-module, csr_counter64, instantiated twice (mcycle, minstret). Inputs: inhibit, incr, wr_lo, wr_hi, wd. Output: 64-bit value.

Test Plan:
- Reset then idle 10 cycles with CY=0 -> mcycle=10; minstret=0; mtvec=MTVEC_RST; csr_illegal_o=0 for 0x300.
- Write mscratch 0xDEAD_BEEF with csr_ra_i=0x340 in the same cycle -> csr_rd_o=0xDEAD_BEEF that cycle via bypass, and again next cycle from the stored value.
- Write mcycle low 0xFFFF_FFFF, then 0xB80 to 0, then 1 free cycle -> mcycleh=1, mcycle=0.
- Pulse instret_incr_i 5 times with mcountinhibit.IR=1 for the last 2 -> minstret=3.
- MIE=1, trap_we_i with mepc 0x8000_0103 and cause 0x8000_000B, plus a csr_we_i to mepc in the same cycle -> mepc=0x8000_0100, mcause=0x8000_000B, MIE=0, MPIE=1; then mret_i -> MIE=1, MPIE=1.
- Read 0x7C0 -> csr_rd_o=0 and csr_illegal_o=1; write misa 0 -> misa still reads MISA_VAL.
